// File: rtl/_fifo32.sv
// _fifo32: 8-entry x 32-bit synchronous FIFO with registered read data
// and one-cycle ack/err pulses driven by a small control FSM.
module _fifo32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [31:0] din,
  input  logic        rd_en,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        rd_ack,
  output logic        rd_err,
  output logic [3:0]  data_count
);
  typedef enum logic [2:0] {INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_mem [8];
  logic [2:0]  r_head, r_tail;
  logic [3:0]  r_count;
  logic [31:0] r_dout;
  logic        r_wr_err, r_rd_ack, r_rd_err;
  logic        w_full, w_empty, w_do_wr, w_do_rd;
  assign w_full  = r_count == 4'd8;
  assign w_empty = r_count == 4'd0;
  assign w_do_wr = wr_en && !w_full;
  assign w_do_rd = rd_en && !w_empty;
  // A performed write dominates the state; a concurrent read shows only in rd_ack/rd_err
  always_comb
    w_next = w_do_wr ? WRITE : w_do_rd ? READ : wr_en ? WR_ERROR : rd_en ? RD_ERROR : NO_OP;
  always_ff @(posedge clk)
    if (w_do_wr) r_mem[r_tail] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= INIT;
      r_head   <= 3'd0;
      r_tail   <= 3'd0;
      r_count  <= 4'd0;
      r_dout   <= 32'h0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_err <= wr_en && w_full;
      r_rd_ack <= w_do_rd;
      r_rd_err <= rd_en && w_empty;
      r_count  <= r_count + {3'b0, w_do_wr} - {3'b0, w_do_rd};
      if (w_do_wr) r_tail <= r_tail + 3'd1;
      if (w_do_rd) begin
        r_dout <= r_mem[r_head];
        r_head <= r_head + 3'd1;
      end
    end
  assign dout       = r_dout;
  assign full       = w_full;
  assign empty      = w_empty;
  assign wr_ack     = r_state == WRITE;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;
  assign data_count = r_count;
endmodule

// File: tb/tb__fifo32.sv
// tb__fifo32: directed self-checking bench for _fifo32.
module tb__fifo32;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  _fifo32 dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags packed as {wr_ack, wr_err, rd_ack, rd_err}
  task automatic chk_all(input string tag, input logic [31:0] d, input logic [3:0] cnt,
                         input logic f, input logic e, input logic [3:0] flags);
    chk({tag, ".dout"}, dout, d);
    chk({tag, ".count"}, {28'h0, data_count}, {28'h0, cnt});
    chk({tag, ".full"}, {31'h0, full}, {31'h0, f});
    chk({tag, ".empty"}, {31'h0, empty}, {31'h0, e});
    chk({tag, ".flags"}, {28'h0, wr_ack, wr_err, rd_ack, rd_err}, {28'h0, flags});
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_all("reset", 32'h0, 4'd0, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_all("idle", 32'h0, 4'd0, 1'b0, 1'b1, 4'b0000);

    step(1, 0, 32'h12345678); chk_all("w1", 32'h0, 4'd1, 1'b0, 1'b0, 4'b1000);
    step(1, 0, 32'h98765432); chk_all("w2", 32'h0, 4'd2, 1'b0, 1'b0, 4'b1000);
    step(1, 0, 32'hffeeddcc); chk_all("w3", 32'h0, 4'd3, 1'b0, 1'b0, 4'b1000);
    step(0, 1, 0); chk_all("r1", 32'h12345678, 4'd2, 1'b0, 1'b0, 4'b0010);
    step(0, 1, 0); chk_all("r2", 32'h98765432, 4'd1, 1'b0, 1'b0, 4'b0010);
    step(0, 1, 0); chk_all("r3", 32'hffeeddcc, 4'd0, 1'b0, 1'b1, 4'b0010);

    step(0, 1, 0); chk_all("rd_empty", 32'hffeeddcc, 4'd0, 1'b0, 1'b1, 4'b0001);
    step(0, 0, 0); chk_all("pulse_clear", 32'hffeeddcc, 4'd0, 1'b0, 1'b1, 4'b0000);

    for (int i = 0; i < 8; i++) step(1, 0, i);
    chk_all("fill8", 32'hffeeddcc, 4'd8, 1'b1, 1'b0, 4'b1000);
    step(1, 0, 32'h8); chk_all("wr_full", 32'hffeeddcc, 4'd8, 1'b1, 1'b0, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("wrap.dout", dout, i);
      chk("wrap.rd_ack", {31'h0, rd_ack}, 32'h1);
    end
    chk_all("drained", 32'h7, 4'd0, 1'b0, 1'b1, 4'b0010);

    step(1, 0, 32'ha0); step(1, 0, 32'ha1); step(1, 0, 32'ha2);
    step(1, 1, 32'hbbaa1234); chk_all("both_mid", 32'ha0, 4'd3, 1'b0, 1'b0, 4'b1010);
    step(0, 1, 0); chk("mid.r1", dout, 32'ha1);
    step(0, 1, 0); chk("mid.r2", dout, 32'ha2);
    step(0, 1, 0); chk_all("mid.r3", 32'hbbaa1234, 4'd0, 1'b0, 1'b1, 4'b0010);
    step(1, 1, 32'h55); chk_all("both_empty", 32'hbbaa1234, 4'd1, 1'b0, 1'b0, 4'b1001);
    step(0, 1, 0); chk_all("empty.rd", 32'h55, 4'd0, 1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 8; i++) step(1, 0, 32'h100 + i);
    step(1, 1, 32'hbbaa1234); chk_all("both_full", 32'h100, 4'd7, 1'b0, 1'b0, 4'b0110);

    step(0, 1, 0); step(0, 1, 0);
    chk_all("count5", 32'h102, 4'd5, 1'b0, 1'b0, 4'b0010);
    wr_en = 1'b0; rd_en = 1'b0;
    #3 reset_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 4'd0, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0); chk_all("post_rst_idle", 32'h0, 4'd0, 1'b0, 1'b1, 4'b0000);
    step(0, 1, 0); chk_all("post_rst_rd", 32'h0, 4'd0, 1'b0, 1'b1, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
